unpack_rq0_lanes: RTL
=====================

UNPACK_RQ0_LANES -- requirements
Module: unpack_rq0_lanes

Interface
REQ-001 Parameter N, 701, number of polynomial coefficients (N >= 3).
REQ-002 Parameter LOG_Q, 13, coefficient width in bits; arithmetic is mod 2^LOG_Q.
REQ-003 Parameter LANES, 2, coefficients accepted per input beat (1..8).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  single-cycle pulse; begins a new unpack.
REQ-007 in_valid  input  1  in_data carries a valid beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  LANES*LOG_Q  lane k at bits [k*LOG_Q +: LOG_Q]; lane 0 is the lowest-index coefficient.
REQ-010 h_mem  output  N*LOG_Q  coefficient i at bits [i*LOG_Q +: LOG_Q].
REQ-011 coef_cnt  output  clog2(N)+1  number of coefficients written so far.
REQ-012 done  output  1  h_mem complete and stable.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, FINAL and DONE.
REQ-014 In IDLE, start=1 SHALL clear coef_cnt and the running sum to 0 and move to LOAD; h_mem is not cleared.
REQ-015 in_ready SHALL be 1 only in LOAD; a beat transfers when in_valid & in_ready are both 1.
REQ-016 On each transfer, lanes k with coef_cnt+k < N-1 SHALL be written to h_mem slot coef_cnt+k and added to the running sum; the remaining lanes SHALL be ignored.
REQ-017 coef_cnt SHALL advance by min(LANES, N-1-coef_cnt) per transfer.
REQ-018 When a transfer brings coef_cnt to N-1, the FSM SHALL move to FINAL on the next edge; LOAD SHALL hold with no change while in_valid=0.
REQ-019 In FINAL, slot N-1 SHALL be written with (2^LOG_Q - sum) mod 2^LOG_Q, where sum is the mod-2^LOG_Q sum of slots 0..N-2; coef_cnt becomes N and the FSM moves to DONE.
REQ-020 The running sum SHALL be LOG_Q bits wide, with overflow wrap-around discarded.
REQ-021 In DONE, done SHALL be 1; start=1 SHALL return the FSM to LOAD, clear coef_cnt and the sum, and drop done on the same edge.
REQ-022 start in LOAD or FINAL SHALL restart the unpack (clear coef_cnt and the sum, state LOAD); a transfer in that same cycle SHALL be discarded.
REQ-023 Latency: done SHALL rise 2 edges after the edge on which the final beat is accepted.
REQ-024 When (N-1) mod LANES != 0, the last beat SHALL be partial; exactly (N-1) mod LANES of its lanes are used.
REQ-025 h_mem slots SHALL change only through write rules REQ-016 and REQ-019.

Reset
REQ-026 rst=0 at a clock edge SHALL set state IDLE, in_ready 0, done 0, coef_cnt 0, sum 0, and every h_mem bit 0.
REQ-027 Reset SHALL take priority over start and over transfers, including mid-LOAD and in FINAL.
REQ-028 The first action after reset SHALL be taken no earlier than the first edge with rst=1.

Verification
REQ-029 N=5, LANES=2, LOG_Q=13; start, then beats {1,2} and {3,4} -> slots 0..3 = 1,2,3,4; slot 4 = 8182; done rises 2 edges after the second beat; coef_cnt=5.
REQ-030 N=6, LANES=4; beats {10,20,30,40} then {50,99,99,99} -> slot 4 = 50, lanes 1..3 of the second beat ignored; slot 5 = 8042; coef_cnt=6.
REQ-031 N=4, LANES=1; coefficients 8191,8191,8191 -> sum wraps to 8189; slot 3 = 3.
REQ-032 in_valid toggled 0/1 every cycle during LOAD -> results identical to back-to-back input; no transfer occurs while in_valid=0.
REQ-033 rst=0 asserted after the second beat of N=701 -> next cycle has h_mem all 0, done=0, in_ready=0; a fresh start followed by a full load completes correctly.
REQ-034 start re-asserted in DONE, then a second load with different data -> done drops on that edge; the final h_mem reflects only the second load.

Source files
------------

// File: rtl/unpack_rq0_lanes.sv
// unpack_rq0_lanes: streams LANES coefficients per beat into h_mem and fills the
// last slot with the negated mod-2^LOG_Q sum so the coefficients sum to zero.
module unpack_rq0_lanes #(
    parameter int N = 701,
    parameter int LOG_Q = 13,
    parameter int LANES = 2,
    localparam int CW = $clog2(N) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*LOG_Q-1:0] in_data,
    output logic [N*LOG_Q-1:0]     h_mem,
    output logic [CW-1:0]          coef_cnt,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, LOAD, FINAL, DONE} state_t;
    state_t r_state, w_next;
    logic [N*LOG_Q-1:0] r_mem;
    logic [LOG_Q-1:0] r_sum, w_add;
    logic [CW-1:0] r_cnt, w_step;
    logic w_xfer, w_full;
    assign w_full = int'(r_cnt) >= N - 1;
    assign w_xfer = r_state == LOAD && in_valid && !start;
    assign in_ready = r_state == LOAD;
    assign done = r_state == DONE;
    assign h_mem = r_mem;
    assign coef_cnt = r_cnt;
    always_comb begin
        w_add = '0;
        w_step = '0;
        for (int k = 0; k < LANES; k++)
            if (int'(r_cnt) + k < N - 1) begin
                w_add = w_add + in_data[k*LOG_Q +: LOG_Q];
                w_step = w_step + CW'(1);
            end
    end
    // Full count is seen one edge after the last beat, giving the LOAD->FINAL->DONE latency.
    always_comb begin
        w_next = start ? LOAD :
                 (r_state == LOAD && w_full) ? FINAL :
                 (r_state == FINAL) ? DONE : r_state;
    end
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem <= '0;
            r_sum <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (w_xfer) begin
            for (int k = 0; k < LANES; k++)
                if (int'(r_cnt) + k < N - 1)
                    r_mem[(int'(r_cnt) + k)*LOG_Q +: LOG_Q] <= in_data[k*LOG_Q +: LOG_Q];
            r_cnt <= r_cnt + w_step;
            r_sum <= r_sum + w_add;
        end else if (r_state == FINAL) begin
            r_mem[(N-1)*LOG_Q +: LOG_Q] <= -r_sum;
            r_cnt <= CW'(N);
        end
    end
endmodule
